hs_fir_tdf: RTL and testbench

HS_FIR_TDF -- requirements
Module: hs_fir_tdf

---
 rtl/hs_fir_pkg.sv | 49 ++++
 rtl/hs_fir_tdf_if.sv | 31 +++
 rtl/hs_fir_tap.sv | 49 ++++
 rtl/hs_fir_tdf.sv | 111 +++++++++++
 tb/tb_hs_fir_tdf.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/hs_fir_pkg.sv
// Shared defaults, accumulator sizing and output rounding/saturation helpers
// for the transposed-form FIR.
package hs_fir_pkg;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_COEF_W = 8;
   localparam int DEF_TAPS   = 8;
   localparam int DEF_OUT_W  = 8;
   localparam int DEF_SHIFT  = 6;

   // Width of the scratch word used by the rounding helpers; covers any legal ACC_W.
   localparam int RS_W = 64;

   function automatic int acc_w(input int data_w, input int coef_w, input int taps);
      return data_w + coef_w + $clog2(taps);
   endfunction

   function automatic logic signed [RS_W-1:0] round_shift(input logic signed [RS_W-1:0] acc,
                                                          input int shift);
      logic signed [RS_W-1:0] half;
      half = RS_W'(1) <<< (shift - 1);
      return (acc + half) >>> shift;
   endfunction

   function automatic logic signed [RS_W-1:0] sat_hi(input int out_w);
      return (RS_W'(1) <<< (out_w - 1)) - RS_W'(1);
   endfunction

   function automatic logic signed [RS_W-1:0] sat_lo(input int out_w);
      return -(RS_W'(1) <<< (out_w - 1));
   endfunction

   function automatic logic signed [RS_W-1:0] rnd_sat_val(input logic signed [RS_W-1:0] acc,
                                                          input int shift, input int out_w);
      logic signed [RS_W-1:0] r;
      r = round_shift(acc, shift);
      if (r > sat_hi(out_w)) return sat_hi(out_w);
      if (r < sat_lo(out_w)) return sat_lo(out_w);
      return r;
   endfunction

   function automatic logic rnd_sat_clip(input logic signed [RS_W-1:0] acc,
                                         input int shift, input int out_w);
      logic signed [RS_W-1:0] r;
      r = round_shift(acc, shift);
      return (r > sat_hi(out_w)) || (r < sat_lo(out_w));
   endfunction

endpackage

// File: rtl/hs_fir_tdf_if.sv
// Sample/result and coefficient-load signal bundle for hs_fir_tdf.
interface hs_fir_tdf_if
   import hs_fir_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int COEF_W = DEF_COEF_W,
   parameter int TAPS   = DEF_TAPS,
   parameter int OUT_W  = DEF_OUT_W
) ();

   logic                       valid;
   logic signed [DATA_W-1:0]   data;
   logic                       coef_we;
   logic [$clog2(TAPS)-1:0]    coef_addr;
   logic signed [COEF_W-1:0]   coef_data;
   logic                       coef_commit;
   logic                       res_valid;
   logic signed [OUT_W-1:0]    res_data;
   logic                       res_sat;

   modport master (
      output valid, data, coef_we, coef_addr, coef_data, coef_commit,
      input  res_valid, res_data, res_sat
   );

   modport slave (
      input  valid, data, coef_we, coef_addr, coef_data, coef_commit,
      output res_valid, res_data, res_sat
   );

endinterface

// File: rtl/hs_fir_tap.sv
// One transposed-form tap: registered coefficient product, then chain add into
// this tap's partial-sum register.
module hs_fir_tap
   import hs_fir_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int COEF_W = DEF_COEF_W,
   parameter int ACC_W  = acc_w(DEF_DATA_W, DEF_COEF_W, DEF_TAPS)
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_load,
   input  logic signed [DATA_W-1:0] i_data,
   input  logic signed [COEF_W-1:0] i_coef,
   input  logic                     i_adv,
   input  logic signed [ACC_W-1:0]  i_chain,
   output logic signed [ACC_W-1:0]  o_chain
);

   localparam int PROD_W = DATA_W + COEF_W;

   logic signed [PROD_W-1:0] prod_p1_d, prod_p1_q;
   logic signed [ACC_W-1:0]  sum_p2_d,  sum_p2_q;

   always_comb begin
      prod_p1_d = prod_p1_q;
      sum_p2_d  = sum_p2_q;
      if (i_load) begin
         prod_p1_d = PROD_W'(i_data) * PROD_W'(i_coef);
      end
      if (i_adv) begin
         sum_p2_d = ACC_W'(prod_p1_q) + i_chain;
      end
   end

   // p1: product of the accepted sample; p2: partial sum passed toward tap 0
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         prod_p1_q <= '0;
         sum_p2_q  <= '0;
      end else begin
         prod_p1_q <= prod_p1_d;
         sum_p2_q  <= sum_p2_d;
      end
   end

   assign o_chain = sum_p2_q;

endmodule

// File: rtl/hs_fir_tdf.sv
// Transposed direct-form FIR with double-buffered coefficients and a
// round/saturate output register; fixed three-cycle sample-to-result latency.
module hs_fir_tdf
   import hs_fir_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int COEF_W = DEF_COEF_W,
   parameter int TAPS   = DEF_TAPS,
   parameter int OUT_W  = DEF_OUT_W,
   parameter int SHIFT  = DEF_SHIFT
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_valid,
   input  logic signed [DATA_W-1:0]   i_data,
   input  logic                       i_coef_we,
   input  logic [$clog2(TAPS)-1:0]    i_coef_addr,
   input  logic signed [COEF_W-1:0]   i_coef_data,
   input  logic                       i_coef_commit,
   output logic                       o_valid,
   output logic signed [OUT_W-1:0]    o_data,
   output logic                       o_sat
);

   localparam int ACC_W = acc_w(DATA_W, COEF_W, TAPS);
   localparam logic signed [COEF_W-1:0] UNITY = COEF_W'(2 ** SHIFT);

   logic signed [COEF_W-1:0] shd_d [TAPS];
   logic signed [COEF_W-1:0] shd_q [TAPS];
   logic signed [COEF_W-1:0] act_d [TAPS];
   logic signed [COEF_W-1:0] act_q [TAPS];

   logic                     vld_p1_d, vld_p1_q;
   logic                     vld_p2_d, vld_p2_q;
   logic                     vld_p3_d, vld_p3_q;
   logic signed [OUT_W-1:0]  dat_p3_d, dat_p3_q;
   logic                     sat_p3_d, sat_p3_q;

   logic signed [ACC_W-1:0]  chain [TAPS+1];

   // A same-cycle write lands in the shadow value that the commit copies.
   always_comb begin
      shd_d = shd_q;
      act_d = act_q;
      if (i_coef_we && (int'(i_coef_addr) < TAPS)) begin
         shd_d[i_coef_addr] = i_coef_data;
      end
      if (i_coef_commit) begin
         act_d = shd_d;
      end
   end

   always_comb begin
      vld_p1_d = i_valid;
      vld_p2_d = vld_p1_q;
      vld_p3_d = vld_p2_q;
      dat_p3_d = dat_p3_q;
      sat_p3_d = sat_p3_q;
      if (vld_p2_q) begin
         dat_p3_d = OUT_W'(rnd_sat_val(RS_W'(chain[0]), SHIFT, OUT_W));
         sat_p3_d = rnd_sat_clip(RS_W'(chain[0]), SHIFT, OUT_W);
      end
   end

   // p0: coefficient banks and sample-valid tracking; p3: rounded output
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         for (int k = 0; k < TAPS; k++) begin
            shd_q[k] <= (k == 0) ? UNITY : '0;
            act_q[k] <= (k == 0) ? UNITY : '0;
         end
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         vld_p3_q <= 1'b0;
         dat_p3_q <= '0;
         sat_p3_q <= 1'b0;
      end else begin
         shd_q    <= shd_d;
         act_q    <= act_d;
         vld_p1_q <= vld_p1_d;
         vld_p2_q <= vld_p2_d;
         vld_p3_q <= vld_p3_d;
         dat_p3_q <= dat_p3_d;
         sat_p3_q <= sat_p3_d;
      end
   end

   assign chain[TAPS] = '0;

   for (genvar k = 0; k < TAPS; k++) begin : g_tap
      hs_fir_tap #(
         .DATA_W (DATA_W),
         .COEF_W (COEF_W),
         .ACC_W  (ACC_W)
      ) u_tap (
         .i_clk   (i_clk),
         .i_reset (i_reset),
         .i_load  (i_valid),
         .i_data  (i_data),
         .i_coef  (act_q[k]),
         .i_adv   (vld_p1_q),
         .i_chain (chain[k+1]),
         .o_chain (chain[k])
      );
   end

   assign o_valid = vld_p3_q;
   assign o_data  = dat_p3_q;
   assign o_sat   = sat_p3_q;

endmodule

// File: tb/tb_hs_fir_tdf.sv
// Bench for hs_fir_tdf: directed vector table, gap-insertion sequence and a
// randomized run against an arithmetic reference model.
module tb_hs_fir_tdf;
   import hs_fir_pkg::*;

   localparam int DATA_W = 8;
   localparam int COEF_W = 8;
   localparam int TAPS   = 8;
   localparam int OUT_W  = 8;
   localparam int SHIFT  = 6;
   localparam int AW     = $clog2(TAPS);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   hs_fir_tdf_if #(.DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W)) bus ();

   hs_fir_tdf #(
      .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W), .SHIFT(SHIFT)
   ) dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_valid       (bus.valid),
      .i_data        (bus.data),
      .i_coef_we     (bus.coef_we),
      .i_coef_addr   (bus.coef_addr),
      .i_coef_data   (bus.coef_data),
      .i_coef_commit (bus.coef_commit),
      .o_valid       (bus.res_valid),
      .o_data        (bus.res_data),
      .o_sat         (bus.res_sat)
   );

   typedef struct {
      bit rst; bit v; int d; bit we; int a; int cd; bit cm;
      bit ev; int ed; bit es;
   } vec_t;
   typedef logic [TAPS-1:0][COEF_W-1:0] bank_t;
   typedef struct { longint due; int d; bit s; } exp_t;

   int     n_vec = 0;
   int     n_bad = 0;
   longint cyc   = 0;
   bank_t  m_act, m_shd;
   int     hx[$];
   bank_t  hb[$];
   exp_t   expq[$];
   int     cap[$];
   vec_t   tbl[$];

   task automatic check(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic bank_t impulse();
      bank_t b;
      b = '0;
      b[0] = COEF_W'(2 ** SHIFT);
      return b;
   endfunction

   // y[n] = sum_k h_n-k[k] * x[n-k], each product using the bank live when its sample arrived
   task automatic model_edge(input bit r, input bit v, input int d, input bit we,
                             input int a, input int cd, input bit cm);
      longint acc, y;
      bit     s;
      cyc++;
      if (r) begin
         hx.delete(); hb.delete(); expq.delete();
         m_act = impulse();
         m_shd = impulse();
      end else begin
         if (v) begin
            hx.push_front(d);
            hb.push_front(m_act);
            if (hx.size() > TAPS) begin
               void'(hx.pop_back());
               void'(hb.pop_back());
            end
            acc = 0;
            for (int k = 0; k < hx.size(); k++)
               acc += longint'($signed(hb[k][k])) * longint'(hx[k]);
            y = (acc + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
            s = 1'b0;
            if (y > 127)  begin y = 127;  s = 1'b1; end
            if (y < -128) begin y = -128; s = 1'b1; end
            expq.push_back('{cyc + 2, int'(y), s});
         end
         if (we && a < TAPS) m_shd[a] = COEF_W'(cd);
         if (cm) m_act = m_shd;
      end
   endtask

   task automatic model_check(input bit r);
      bit ev;
      ev = (expq.size() > 0) && (expq[0].due == cyc);
      check("model.o_valid", int'(bus.res_valid), int'(ev));
      if (ev) begin
         check("model.o_data", int'($signed(bus.res_data)), expq[0].d);
         check("model.o_sat", int'(bus.res_sat), int'(expq[0].s));
         void'(expq.pop_front());
      end else if (r) begin
         check("model.o_data_rst", int'($signed(bus.res_data)), 0);
         check("model.o_sat_rst", int'(bus.res_sat), 0);
      end
   endtask

   task automatic step(input bit r, input bit v, input int d, input bit we,
                       input int a, input int cd, input bit cm);
      rst             = r;
      bus.valid       = v;
      bus.data        = DATA_W'(d);
      bus.coef_we     = we;
      bus.coef_addr   = AW'(a);
      bus.coef_data   = COEF_W'(cd);
      bus.coef_commit = cm;
      @(posedge clk);
      model_edge(r, v, d, we, a, cd, cm);
      #1;
      model_check(r);
      if (bus.res_valid) cap.push_back(int'($signed(bus.res_data)));
   endtask

   function automatic vec_t mk(bit r, bit v, int d, bit we, int a, int cd, bit cm,
                               bit ev, int ed, bit es);
      vec_t t;
      t.rst = r; t.v = v; t.d = d; t.we = we; t.a = a; t.cd = cd; t.cm = cm;
      t.ev = ev; t.ed = ed; t.es = es;
      return t;
   endfunction

   function automatic vec_t rr();                              return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);   endfunction
   function automatic vec_t smp(int d, bit ev, int ed, bit es); return mk(0, 1, d, 0, 0, 0, 0, ev, ed, es); endfunction
   function automatic vec_t idl(bit ev, int ed, bit es);        return mk(0, 0, 0, 0, 0, 0, 0, ev, ed, es); endfunction
   function automatic vec_t wr(int a, int cd, bit cm);          return mk(0, 0, 0, 1, a, cd, cm, 0, 0, 0); endfunction
   function automatic vec_t cmt();                              return mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);   endfunction

   initial begin
      int gexp [3];
      bit r, v, we, cm;
      int d, a, cd;

      bus.valid = 1'b0; bus.data = '0; bus.coef_we = 1'b0; bus.coef_addr = '0;
      bus.coef_data = '0; bus.coef_commit = 1'b0;

      // impulse passthrough after reset
      tbl.push_back(rr()); tbl.push_back(rr());
      tbl.push_back(smp(37, 0, 0, 0)); tbl.push_back(smp(0, 0, 0, 0));
      tbl.push_back(smp(0, 1, 37, 0)); tbl.push_back(idl(1, 0, 0));
      tbl.push_back(idl(1, 0, 0));     tbl.push_back(idl(0, 0, 0));
      // two-tap moving sum
      tbl.push_back(rr()); tbl.push_back(wr(1, 64, 0)); tbl.push_back(cmt());
      tbl.push_back(smp(10, 0, 0, 0)); tbl.push_back(smp(20, 0, 0, 0));
      tbl.push_back(smp(30, 1, 10, 0)); tbl.push_back(idl(1, 30, 0));
      tbl.push_back(idl(1, 50, 0));    tbl.push_back(idl(0, 0, 0));
      // saturation both directions
      tbl.push_back(rr()); tbl.push_back(wr(0, 127, 1));
      tbl.push_back(smp(127, 0, 0, 0)); tbl.push_back(smp(-128, 0, 0, 0));
      tbl.push_back(idl(1, 127, 1));    tbl.push_back(idl(1, -128, 1));
      tbl.push_back(idl(0, 0, 0));
      // uncommitted write invisible; write+commit in the same cycle
      tbl.push_back(rr()); tbl.push_back(wr(0, 10, 0));
      tbl.push_back(smp(20, 0, 0, 0)); tbl.push_back(idl(0, 0, 0));
      tbl.push_back(idl(1, 20, 0));    tbl.push_back(wr(0, 32, 1));
      tbl.push_back(smp(20, 0, 0, 0)); tbl.push_back(idl(0, 0, 0));
      tbl.push_back(idl(1, 10, 0));    tbl.push_back(idl(0, 0, 0));
      // reset with the pipeline full
      tbl.push_back(rr());
      tbl.push_back(smp(1, 0, 0, 0)); tbl.push_back(smp(2, 0, 0, 0));
      tbl.push_back(smp(3, 1, 1, 0)); tbl.push_back(rr());
      tbl.push_back(smp(37, 0, 0, 0)); tbl.push_back(idl(0, 0, 0));
      tbl.push_back(idl(1, 37, 0));    tbl.push_back(idl(0, 0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].rst, tbl[i].v, tbl[i].d, tbl[i].we, tbl[i].a, tbl[i].cd, tbl[i].cm);
         check($sformatf("tbl[%0d].o_valid", i), int'(bus.res_valid), int'(tbl[i].ev));
         if (tbl[i].ev || tbl[i].rst) begin
            check($sformatf("tbl[%0d].o_data", i), int'($signed(bus.res_data)), tbl[i].ed);
            check($sformatf("tbl[%0d].o_sat", i), int'(bus.res_sat), int'(tbl[i].es));
         end
      end

      // two-tap sequence with random idle gaps between samples
      gexp = '{10, 30, 50};
      step(1, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 1, 64, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      cap.delete();
      for (int s = 0; s < 3; s++) begin
         step(0, 1, 10 * (s + 1), 0, 0, 0, 0);
         repeat ($urandom_range(0, 5)) step(0, 0, 0, 0, 0, 0, 0);
      end
      repeat (6) step(0, 0, 0, 0, 0, 0, 0);
      check("gap.result_count", cap.size(), 3);
      for (int k = 0; k < 3; k++)
         check($sformatf("gap.y[%0d]", k), (k < cap.size()) ? cap[k] : -999, gexp[k]);

      // randomized traffic, coefficient updates and occasional reset
      step(1, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(0, 199) == 0);
         v  = ($urandom_range(0, 3) != 0);
         d  = int'($urandom_range(0, 255)) - 128;
         we = ($urandom_range(0, 2) == 0);
         a  = int'($urandom_range(0, TAPS - 1));
         cd = $urandom_range(0, 1) ? int'($urandom_range(0, 255)) - 128
                                   : int'($urandom_range(0, 40)) - 20;
         cm = ($urandom_range(0, 15) == 0);
         step(r, v, d, we, a, cd, cm);
      end
      repeat (4) step(0, 0, 0, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
